mxv_result_serializer: RTL and testbench
========================================

Name: mxv_result_serializer

Overview:
- Sits directly downstream of matrix_by_vector_v3_with_control.
- Captures each wide result word (NI elements) presented with the outsider_read_now strobe into a small word FIFO.
- Drains the FIFO one element per cycle over a valid/ready stream toward the vector-update stage.
- Counts delivered elements against total_with_additional_A from parameters_mem, and flags end-of-vector and overflow.

Parameters:
- element_width, 32, bits per element
- NI, 8, elements per captured result word (no_of_units)
- FIFO_DEPTH, 4, word entries; power of two, at least 2
- FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- result_in  in  NI*element_width  wide result word (mXv1_result); element 0 in the MSBs [NI*element_width-1 -: element_width]
- result_valid  in  1  one-cycle capture strobe (outsider_read_now)
- total_elements  in  32  number of elements to deliver (total_with_additional_A); must be stable from reset release onward
- elem_out  out  element_width  current element
- elem_valid  out  1  elem_out is valid
- elem_ready  in  1  consumer accepts elem_out
- elem_last  out  1  the current element is the final one
- done  out  1  sticky; all total_elements elements delivered
- overflow  out  1  sticky; a capture was dropped because the FIFO was full
- fifo_level  out  FIFO_AW+1  number of occupied word entries

Behaviour:
- All state updates on posedge clk. While reset=1:
  - state=IDLE
  - FIFO pointers=0, fifo_level=0
  - element index=0, element count=0
  - done=0, overflow=0
- Outputs while in reset: elem_valid=0, elem_last=0; elem_out is don't-care, and the bench checks it only when elem_valid=1.
- State machine:
  - IDLE: for exactly one cycle after reset release, latches total_elements into tot_r. Next state is DONE if tot_r=0 (done=1 the following cycle), otherwise RUN.
  - RUN: streams elements. Moves to DONE on the cycle the element with count=tot_r-1 transfers.
  - DONE: terminal until reset. Sets done=1, flushes the FIFO, and ignores result_valid. Neither the stream nor overflow changes while in DONE.
- Capture:
  - In IDLE or RUN, result_valid=1 with the FIFO not full writes result_in at the write pointer.
  - Write-pointer and read-pointer wrap modulo FIFO_DEPTH; full and empty are derived from fifo_level.
  - A capture in the IDLE cycle is accepted.
- Full with simultaneous pop: if the FIFO is full but a head-word pop (defined under Serializing) happens in the same cycle, the write is accepted and fifo_level stays unchanged.
- Full with no pop: the write is dropped and overflow is set (sticky).
- Serializing:
  - elem_valid = (state==RUN) && FIFO not empty.
  - elem_out is combinational from the head word: element[index], MSB-first.
  - A transfer occurs when elem_valid && elem_ready. On transfer, count increments by 1 and index increments by 1.
  - When index=NI-1 transfers, index returns to 0 and the head word pops.
  - When elem_valid=0, index and count are held.
- elem_last = elem_valid && (count == tot_r-1).
- A transfer with elem_last=1 ends the vector:
  - The partially consumed head word and all later words are discarded (FIFO cleared on entry to DONE).
  - index resets to 0.
- Arithmetic:
  - count is 32 bits and compared with tot_r exactly; no saturation is needed because DONE stops counting.
  - index has a width of clog2(NI); when NI=1, index is constant 0 and every transfer pops the head word.
- Latency: a word captured into an empty FIFO in RUN yields elem_valid=1 on the next cycle.
- Throughput: one element per cycle with elem_ready held high.
- Reset asserted mid-stream: all state clears on the next edge with no partial output, and tot_r is re-latched after release.

Optional Feature:
- Macro: MXV_RESULT_CHECKSUM_EN.
- When defined:
  - Adds output checksum [element_width-1:0].
  - checksum resets to 0.
  - On every transfer, checksum <= checksum + elem_out, wrapping modulo 2^element_width.
  - checksum is held once done=1.
- When not defined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- NI=8, total=16, two captures of elements 1..8 and 9..16, elem_ready=1 → 16 consecutive transfers with values 1..16; elem_last on value 16; done=1 the cycle after; fifo_level returns to 0.
- total=12, two captures (1..8, 9..16) → elem_last on value 12; values 13..16 never appear; fifo_level=0 once done=1.
- FIFO_DEPTH=4, elem_ready=0, five captures → fifo_level=4 and overflow=1 after the fifth capture; on release of elem_ready, the first 32 elements drain in order and the fifth word is absent.
- FIFO full, elem_ready=1, index=7, capture strobe in the same cycle → write accepted, fifo_level stays 4, overflow=0.
- total=0 → done=1 two cycles after reset release; elem_valid is never 1; a later capture leaves fifo_level=0.
- Reset pulsed after 5 of 16 transfers, then re-run → outputs clear, and the post-reset stream restarts at element 0 of the new capture. With MXV_RESULT_CHECKSUM_EN defined, 1..16 gives checksum=136.

Source files
------------

// File: rtl/mxv_result_serializer_if.sv
// Stream interface for mxv_result_serializer: wide result capture in,
// one element per cycle out over valid/ready.
interface mxv_result_serializer_if #(
    parameter int element_width = 32,
    parameter int NI            = 8
);
    logic [NI*element_width-1:0] result_in;
    logic                        result_valid;
    logic [element_width-1:0]    elem_out;
    logic                        elem_valid;
    logic                        elem_ready;
    logic                        elem_last;

    // Serializer side: consumes results, produces the element stream.
    modport master (
        input  result_in,
        input  result_valid,
        input  elem_ready,
        output elem_out,
        output elem_valid,
        output elem_last
    );

    // Environment side: producer of results and consumer of elements.
    modport slave (
        output result_in,
        output result_valid,
        output elem_ready,
        input  elem_out,
        input  elem_valid,
        input  elem_last
    );
endinterface

// File: rtl/mxv_result_serializer.sv
// Buffers wide matrix-by-vector results and streams them element by element.
// Optional running checksum output: define MXV_RESULT_CHECKSUM_EN.
module mxv_result_serializer #(
    parameter int element_width = 32,
    parameter int NI            = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int FIFO_AW       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mxv_result_serializer_if.master bus,
    input  logic [31:0]          total_elements,
    output logic                 done,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifo_level
`ifdef MXV_RESULT_CHECKSUM_EN
    ,
    output logic [element_width-1:0] checksum
`endif
);

    localparam int WW = NI * element_width;
    localparam int IW = (NI > 1) ? $clog2(NI) : 1;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [31:0]          tot_r;
    logic [31:0]          count;
    logic [IW-1:0]        idx;
    logic [WW-1:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [WW-1:0]        head;
    logic [element_width-1:0] elem_sel;

    logic full;
    logic empty;
    logic valid;
    logic last;
    logic xfer;
    logic idx_end;
    logic pop;
    logic push;
    logic drop;
    logic flush;

    assign full    = (fifo_level == DEPTH_L);
    assign empty   = (fifo_level == '0);
    assign head    = mem[rd_ptr];
    assign valid   = (state == RUN) && !empty;
    assign last    = valid && (count == tot_r - 32'd1);
    assign xfer    = valid && bus.elem_ready;
    assign idx_end = (int'(idx) == NI - 1);
    assign pop     = xfer && idx_end;
    assign flush   = (state_n == DONE);
    assign push    = (state != DONE) && bus.result_valid && (!full || pop);
    assign drop    = (state != DONE) && bus.result_valid && full && !pop;

    assign bus.elem_valid = valid;
    assign bus.elem_last  = last;
    assign bus.elem_out   = elem_sel;

    // Pick element[idx] of the head word; element 0 sits in the MSBs.
    always_comb begin
        elem_sel = '0;
        for (int i = 0; i < NI; i++) begin
            if (int'(idx) == i) begin
                elem_sel = head[WW-1-i*element_width -: element_width];
            end
        end
    end

    // Next-state logic: one latch cycle, stream, then park until reset.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (total_elements == 32'd0) ? DONE : RUN;
            RUN:     if (xfer && last) state_n = DONE;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Latch the vector length during the single IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tot_r <= '0;
        end else if (state == IDLE) begin
            tot_r <= total_elements;
        end
    end

    // Word storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.result_in;
        end
    end

    // FIFO pointers and occupancy; cleared when the vector completes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // Element index within the head word and delivered-element count.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx   <= '0;
            count <= '0;
        end else if (xfer) begin
            count <= count + 32'd1;
            if (last || idx_end) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Sticky completion and dropped-capture flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                done <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MXV_RESULT_CHECKSUM_EN
    // Wrapping sum of every delivered element; frozen after completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (xfer && !done) begin
            checksum <= checksum + elem_sel;
        end
    end
`endif

endmodule

// File: tb/tb_mxv_result_serializer.sv
// Directed bench for mxv_result_serializer: table of full-vector runs
// plus hand sequences for overflow, full-with-pop, empty vector, reset.
module tb_mxv_result_serializer;

    localparam int W  = 32;
    localparam int NI = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   total_elements = '0;
    logic          done;
    logic          overflow;
    logic [AW:0]   fifo_level;
`ifdef MXV_RESULT_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    mxv_result_serializer_if #(.element_width(W), .NI(NI)) bus ();

    mxv_result_serializer #(
        .element_width(W),
        .NI(NI),
        .FIFO_DEPTH(D),
        .FIFO_AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .total_elements(total_elements),
        .done(done),
        .overflow(overflow),
        .fifo_level(fifo_level)
`ifdef MXV_RESULT_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int total;
        int ncap;
        int base;
        int exp_last;
        int exp_sum;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NI*W-1:0] mkword(input int first);
        logic [NI*W-1:0] w;
        w = '0;
        for (int i = 0; i < NI; i++) begin
            w[NI*W-1-i*W -: W] = 32'(first + i);
        end
        return w;
    endfunction

    task automatic apply_reset(input int total);
        @(negedge clk);
        reset = 1'b1;
        total_elements = 32'(total);
        bus.result_valid = 1'b0;
        bus.result_in = '0;
        bus.elem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.elem_valid), 32'd0);
        check("rst_last", 32'(bus.elem_last), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef MXV_RESULT_CHECKSUM_EN
        check("rst_csum", checksum, 32'd0);
`endif
    endtask

    task automatic run_case(input int total, input int ncap, input int base,
                            input int exp_last, input int exp_sum);
        int k;
        int c;
        int cyc;
        logic [31:0] sum;
        bit seen_last;
        bit fin;
        apply_reset(total);
        bus.elem_ready = 1'b1;
        reset = 1'b0;
        k = 0;
        c = 0;
        cyc = 0;
        sum = '0;
        seen_last = 0;
        fin = 0;
        while (!fin && cyc < 200) begin
            if (c < ncap) begin
                bus.result_valid = 1'b1;
                bus.result_in = mkword(base + c * NI + 1);
                c++;
            end else begin
                bus.result_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (seen_last) begin
                check("run_done", 32'(done), 32'd1);
                check("run_level0", 32'(fifo_level), 32'd0);
                check("run_valid_off", 32'(bus.elem_valid), 32'd0);
                fin = 1;
            end else if (bus.elem_valid) begin
                check("run_value", bus.elem_out, 32'(base + k + 1));
                check("run_lastflag", 32'(bus.elem_last),
                      32'(k == total - 1));
                sum = sum + bus.elem_out;
                if (bus.elem_last) begin
                    check("run_lastval", bus.elem_out, 32'(exp_last));
                    seen_last = 1;
                end
                k++;
            end
        end
        bus.result_valid = 1'b0;
        check("run_count", 32'(k), 32'(total));
        check("run_finished", 32'(fin), 32'd1);
        check("run_sum", sum, 32'(exp_sum));
`ifdef MXV_RESULT_CHECKSUM_EN
        check("run_csum", checksum, 32'(exp_sum));
`endif
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.result_in = '0;
        bus.elem_ready = 1'b0;

        tbl[0] = '{total: 16, ncap: 2, base: 0,   exp_last: 16,  exp_sum: 136};
        tbl[1] = '{total: 12, ncap: 2, base: 0,   exp_last: 12,  exp_sum: 78};
        tbl[2] = '{total: 8,  ncap: 1, base: 0,   exp_last: 8,   exp_sum: 36};
        tbl[3] = '{total: 3,  ncap: 1, base: 40,  exp_last: 43,  exp_sum: 126};
        tbl[4] = '{total: 20, ncap: 3, base: 100, exp_last: 120, exp_sum: 2210};

        for (int i = 0; i < 5; i++) begin
            run_case(tbl[i].total, tbl[i].ncap, tbl[i].base,
                     tbl[i].exp_last, tbl[i].exp_sum);
        end

        // Overflow: five captures with the consumer stalled.
        begin
            int k;
            apply_reset(64);
            reset = 1'b0;
            for (int c = 0; c < 5; c++) begin
                bus.result_valid = 1'b1;
                bus.result_in = mkword(c * NI + 1);
                @(negedge clk);
            end
            bus.result_valid = 1'b0;
            check("ovf_level", 32'(fifo_level), 32'd4);
            check("ovf_flag", 32'(overflow), 32'd1);
            check("ovf_head", bus.elem_out, 32'd1);
            bus.elem_ready = 1'b1;
            k = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                if (bus.elem_valid) begin
                    check("ovf_drain", bus.elem_out, 32'(k + 1));
                    k++;
                end
                @(negedge clk);
            end
            check("ovf_count", 32'(k), 32'd32);
            check("ovf_empty", 32'(fifo_level), 32'd0);
            check("ovf_notdone", 32'(done), 32'd0);
        end

        // Full FIFO with a pop and a capture in the same cycle.
        begin
            int k;
            bit probe;
            apply_reset(64);
            reset = 1'b0;
            for (int c = 0; c < 4; c++) begin
                bus.result_valid = 1'b1;
                bus.result_in = mkword(c * NI + 1);
                @(negedge clk);
            end
            bus.result_valid = 1'b0;
            check("fp_full", 32'(fifo_level), 32'd4);
            bus.elem_ready = 1'b1;
            k = 0;
            for (int cyc = 0; cyc < 50; cyc++) begin
                probe = 0;
                bus.result_valid = 1'b0;
                if (bus.elem_valid) begin
                    check("fp_value", bus.elem_out, 32'(k + 1));
                    if (k == 7) begin
                        bus.result_valid = 1'b1;
                        bus.result_in = mkword(33);
                        probe = 1;
                    end
                    k++;
                end
                @(negedge clk);
                if (probe) begin
                    check("fp_level_kept", 32'(fifo_level), 32'd4);
                    check("fp_no_ovf", 32'(overflow), 32'd0);
                end
            end
            bus.result_valid = 1'b0;
            check("fp_count", 32'(k), 32'd40);
        end

        // Empty vector: straight to done, captures ignored.
        begin
            bit saw_valid;
            apply_reset(0);
            reset = 1'b0;
            saw_valid = 0;
            @(negedge clk);
            saw_valid |= bus.elem_valid;
            @(negedge clk);
            saw_valid |= bus.elem_valid;
            check("z_done", 32'(done), 32'd1);
            bus.result_valid = 1'b1;
            bus.result_in = mkword(1);
            bus.elem_ready = 1'b1;
            @(negedge clk);
            saw_valid |= bus.elem_valid;
            bus.result_valid = 1'b0;
            @(negedge clk);
            saw_valid |= bus.elem_valid;
            check("z_level", 32'(fifo_level), 32'd0);
            check("z_never_valid", 32'(saw_valid), 32'd0);
            check("z_no_ovf", 32'(overflow), 32'd0);
        end

        // Reset after five transfers, then a fresh vector.
        begin
            int k;
            int cyc;
            apply_reset(16);
            bus.elem_ready = 1'b1;
            reset = 1'b0;
            k = 0;
            cyc = 0;
            while (k < 5 && cyc < 50) begin
                bus.result_valid = (cyc < 2);
                bus.result_in = mkword(cyc * NI + 1);
                @(negedge clk);
                cyc++;
                if (bus.elem_valid) k++;
            end
            bus.result_valid = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("mr_valid", 32'(bus.elem_valid), 32'd0);
            check("mr_level", 32'(fifo_level), 32'd0);
            check("mr_done", 32'(done), 32'd0);
`ifdef MXV_RESULT_CHECKSUM_EN
            check("mr_csum", checksum, 32'd0);
`endif
            run_case(16, 2, 200, 216, 3336);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
